i2c_slave_regbank: RTL and testbench
====================================

// Module: i2c_slave_regbank
// PURPOSE
//  Parametrised I2C target with an N-deep byte register bank, replacing the fixed 4-register slave.
//  Adds a register pointer byte, multi-byte burst write/read with auto-increment and pointer wrap,
//  and repeated-START support. Sits between the board SCL/SDA pins and display/ranking consumers.
// PARAMETERS
//  SLV_ADDR   7'h42  7-bit I2C target address
//  NUM_REGS   4      register count, 2..256; pointer width PTR_W = $clog2(NUM_REGS)
//  FILT_LEN   3      samples SCL/SDA must be stable before a level is accepted (glitch filter)
// PORTS
//  clk        in   1             system clock, >= 10x SCL rate
//  reset      in   1             synchronous reset, active-low
//  SCL        in   1             I2C clock from master (asynchronous)
//  SDA        inout 1            I2C data, open-drain: driven 0 or Z only
//  regs_flat  out  NUM_REGS*8    register bank, reg k at [8k+7:8k]
//  wr_strobe  out  1             1-cycle pulse when a data byte is committed
//  wr_index   out  PTR_W         index written on wr_strobe
//  busy       out  1             high from START to STOP for this target
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all regs 0, pointer 0, FSM IDLE, SDA released (Z), strobes/busy 0.
//    Reset mid-transfer: SDA released the same cycle; bus ignored until next START.
//  - Input path: 2-FF sync, then FILT_LEN-sample filter. Edge detect on filtered signals.
//  - START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both valid in any state;
//    START (incl. repeated) -> ADDR, bit count 0. STOP -> IDLE, busy=0.
//  - Bits sampled on SCL rise. SDA is changed only on SCL fall; SDA is held through SCL high.
//  - FSM: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
//    ADDR: shift 8 bits MSB-first. Addr match -> ADDR_ACK (drive 0 for 9th clock);
//      mismatch -> WAIT_STOP, no ACK, busy=0.
//    ADDR_ACK: R/W=0 -> PTR; R/W=1 -> RDATA (first byte = regs[pointer]).
//    PTR: byte < NUM_REGS -> load pointer, ACK, then WDATA; else NACK, pointer unchanged -> WAIT_STOP.
//    WDATA: on 8th SCL rise write byte to regs[pointer], pulse wr_strobe with wr_index=pointer,
//      ACK, pointer+1 (wrap NUM_REGS-1 -> 0), stay in WDATA loop.
//    RDATA: shift regs[pointer] MSB-first; byte is latched at the first bit's SCL fall,
//      so a concurrent write does not tear it. RDATA_ACK samples master:
//      ACK -> pointer+1 (wrap), next byte; NACK -> WAIT_STOP, pointer advanced.
//    WAIT_STOP: SDA released; exit only on STOP or START.
//  - Pointer persists across transactions (write-ptr-only then read resumes there).
//  - START/STOP mid-byte aborts: partial byte discarded, no register write.
//  - Register write latency: regs_flat updates 1 clk after the 8th data-bit SCL rise. wr_strobe is high in that cycle.
// STRUCTURE
//  - Package i2c_pkg: state enum type, ACK/NACK constants, sync depth constant.
//  - Sub-module i2c_line_filter: sync + FILT_LEN filter + rise/fall outputs, one instance each for SCL and SDA.
//  - The top holds the FSM, shift register, bit counter, pointer and register bank.
// TESTING
//  - Write burst: S,0x84,0x01,0xAA,0xBB,P (NUM_REGS=4) -> reg1=AA, reg2=BB, two wr_strobe (idx 1,2), all ACK.
//  - Wrap: S,0x84,0x03,0x11,0x22,P -> reg3=11, reg0=22, pointer ends 1.
//  - Read repeated-START: S,0x84,0x02,Sr,0x85, read 3 bytes ACK,ACK,NACK,P -> data reg2,reg3,reg0.
//  - Wrong addr S,0xA0,...: no ACK, SDA never driven, regs unchanged, busy stays 0.
//  - Bad pointer S,0x84,0x07: pointer byte NACKed, following bytes not ACKed, regs unchanged.
//  - Abort and reset: STOP after 4 data bits -> no write. reset low during RDATA -> SDA=Z next clk, regs=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-bank target.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser plus FILT_LEN-sample glitch filter for one I2C line, with
// single-cycle rise/fall pulses aligned to the filtered level change.
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_DEPTH-1:0] sync;
  logic [FILT_LEN-1:0]   hist;

  // Idle bus is high, so everything resets to 1 to avoid a false edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '1;
      hist  <= '1;
      level <= 1'b1;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], line};
      hist <= {hist[FILT_LEN-2:0], sync[SYNC_DEPTH-1]};
      rise <= 1'b0;
      fall <= 1'b0;
      if (&hist && !level) begin
        level <= 1'b1;
        rise  <= 1'b1;
      end else if (!(|hist) && level) begin
        level <= 1'b0;
        fall  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_regbank.sv
// I2C target with an N-deep byte register bank, pointer byte, burst
// write/read with auto-increment and wrap, and repeated-START support.
module i2c_slave_regbank
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLV_ADDR = 7'h42,
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned FILT_LEN = 3,
  localparam int unsigned PTR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCL,
  inout  wire                   SDA,
  output logic [NUM_REGS*8-1:0] regs_flat,
  output logic                  wr_strobe,
  output logic [PTR_W-1:0]      wr_index,
  output logic                  busy
);

  logic scl_level, scl_rise, scl_fall;
  logic sda_level, sda_rise, sda_fall;
  logic start_det, stop_det;

  state_t           state, state_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shift, shift_n, tx, tx_n, rx_byte;
  logic [PTR_W-1:0] ptr, ptr_n, ptr_inc;
  logic             rd, rd_n, sda_oe, oe_n, busy_n, we;
  logic [7:0]       regs [NUM_REGS];

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk   (clk),
    .reset (reset),
    .line  (SCL),
    .level (scl_level),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk   (clk),
    .reset (reset),
    .line  (SDA),
    .level (sda_level),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  assign SDA       = sda_oe ? 1'b0 : 1'bz;
  assign start_det = sda_fall & scl_level;
  assign stop_det  = sda_rise & scl_level;
  assign rx_byte   = {shift[6:0], sda_level};
  assign ptr_inc   = (ptr == PTR_W'(NUM_REGS - 1)) ? '0 : ptr + PTR_W'(1);

  always_comb begin
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_flat[8*k +: 8] = regs[k];
  end

  // SDA is only ever changed on SCL fall; ACK states drive low for the 9th
  // clock and hand over to the next state on that clock's rise.
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    ptr_n   = ptr;
    rd_n    = rd;
    oe_n    = sda_oe;
    busy_n  = busy;
    we      = 1'b0;
    if (start_det) begin
      state_n = ST_ADDR;
      bit_n   = '0;
      oe_n    = 1'b0;
    end else if (stop_det) begin
      state_n = ST_IDLE;
      bit_n   = '0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else if (scl_fall) begin
      case (state)
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: oe_n = ~ACK;
        ST_RDATA: begin
          if (bit_cnt == 3'd0) begin
            oe_n = ~regs[ptr][7];
            tx_n = {regs[ptr][6:0], 1'b0};
          end else begin
            oe_n = ~tx[7];
            tx_n = {tx[6:0], 1'b0};
          end
        end
        default: oe_n = 1'b0;
      endcase
    end else if (scl_rise) begin
      case (state)
        ST_ADDR: begin
          shift_n = rx_byte;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (rx_byte[7:1] == SLV_ADDR) begin
              state_n = ST_ADDR_ACK;
              rd_n    = rx_byte[0];
              busy_n  = 1'b1;
            end else begin
              state_n = ST_WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          state_n = rd ? ST_RDATA : ST_PTR;
          bit_n   = '0;
        end
        ST_PTR: begin
          shift_n = rx_byte;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (32'(rx_byte) < NUM_REGS) begin
              ptr_n   = rx_byte[PTR_W-1:0];
              state_n = ST_PTR_ACK;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          state_n = ST_WDATA;
          bit_n   = '0;
        end
        ST_WDATA: begin
          shift_n = rx_byte;
          bit_n   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            we      = 1'b1;
            ptr_n   = ptr_inc;
            state_n = ST_WDATA_ACK;
          end
        end
        ST_RDATA: begin
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = ST_RDATA_ACK;
        end
        ST_RDATA_ACK: begin
          ptr_n   = ptr_inc;
          bit_n   = '0;
          state_n = (sda_level == ACK) ? ST_RDATA : ST_WAIT_STOP;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      ptr       <= '0;
      rd        <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_index  <= '0;
      for (int unsigned k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_n;
      shift     <= shift_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      rd        <= rd_n;
      sda_oe    <= oe_n;
      busy      <= busy_n;
      wr_strobe <= we;
      if (we) begin
        regs[ptr] <= rx_byte;
        wr_index  <= ptr;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regbank.sv
// Bench for i2c_slave_regbank: bit-level I2C master, transaction-level
// register/pointer model, and a compare process fed at byte boundaries.
module tb_i2c_slave_regbank;

  localparam int unsigned NREG = 4;
  localparam int          QT   = 100;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              scl = 1'b1;
  logic              m_sda = 1'b1;
  wire               SDA;
  logic [NREG*8-1:0] regs_flat;
  logic              wr_strobe;
  logic [1:0]        wr_index;
  logic              busy;

  assign SDA = m_sda ? 1'bz : 1'b0;
  pullup (SDA);

  always #5 clk = ~clk;

  i2c_slave_regbank #(.SLV_ADDR(7'h42), .NUM_REGS(NREG), .FILT_LEN(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .SCL       (scl),
    .SDA       (SDA),
    .regs_flat (regs_flat),
    .wr_strobe (wr_strobe),
    .wr_index  (wr_index),
    .busy      (busy)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] m_regs [NREG];
  int         m_ptr;
  logic       m_busy;
  int         exp_q[$];
  int         got_q[$];
  event       cmp_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sda_in();
    return (SDA === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [NREG*8-1:0] m_pack();
    logic [NREG*8-1:0] v;
    for (int k = 0; k < NREG; k++) v[8*k +: 8] = m_regs[k];
    return v;
  endfunction

  always @(negedge clk)
    if (wr_strobe) got_q.push_back(int'(wr_index) * 256 + int'(regs_flat[wr_index*8 +: 8]));

  always begin
    @(cmp_ev);
    @(negedge clk);
    chk("regs", regs_flat, m_pack());
    chk("busy", busy, m_busy);
    chk("strobe_cnt", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("strobe", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  end

  task automatic sync_cmp();
    -> cmp_ev;
    #20;
  endtask

  task automatic tx_bit(input logic b, output logic s);
    m_sda = b; #QT;
    scl = 1'b1; #QT;
    s = sda_in(); #QT;
    scl = 1'b0; #QT;
  endtask

  task automatic rx_bit(output logic s);
    tx_bit(1'b1, s);
  endtask

  task automatic start();
    m_sda = 1'b1; #QT;
    scl = 1'b1; #QT;
    m_sda = 1'b0; #QT;
    scl = 1'b0; #QT;
  endtask

  task automatic stop_t();
    m_sda = 1'b0; #QT;
    scl = 1'b1; #QT;
    m_sda = 1'b1; #QT;
    #QT;
    m_busy = 1'b0;
    sync_cmp();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      tx_bit(b[i], s);
      if (b[i]) chk({name, "_line"}, s, 1'b1);
    end
    tx_bit(1'b1, s);
    chk({name, "_ack"}, s, exp_ack ? 1'b0 : 1'b1);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      rx_bit(s);
      d[i] = s;
    end
    m_sda = mack ? 1'b0 : 1'b1; #QT;
    scl = 1'b1; #QT;
    #QT;
    scl = 1'b0; #(QT/2);
    m_sda = 1'b1; #(QT/2);
  endtask

  task automatic addr_phase(input logic [7:0] a, output logic hit);
    hit = (a[7:1] == 7'h42);
    send_byte(a, hit, "addr");
    m_busy = hit;
    sync_cmp();
  endtask

  task automatic w_ptr(input logic [7:0] p, input logic live, output logic ok);
    ok = live && (p < NREG);
    send_byte(p, ok, "ptr");
    if (ok) m_ptr = int'(p);
    sync_cmp();
  endtask

  task automatic w_data(input logic [7:0] d, input logic ok);
    send_byte(d, ok, "wdata");
    if (ok) begin
      m_regs[m_ptr] = d;
      exp_q.push_back(m_ptr * 256 + int'(d));
      m_ptr = (m_ptr + 1) % NREG;
    end
    sync_cmp();
  endtask

  task automatic r_data(input logic mack, output logic [7:0] d);
    logic [7:0] e;
    e = m_regs[m_ptr];
    recv_byte(mack, d);
    chk("rdata", d, e);
    m_ptr = (m_ptr + 1) % NREG;
    sync_cmp();
  endtask

  initial begin
    logic       hit, ok, s;
    logic [7:0] d, pat;

    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_ptr  = 0;
    m_busy = 1'b0;

    repeat (5) @(posedge clk);
    #1;
    chk("rst_regs", regs_flat, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_sda", sda_in(), 1'b1);
    @(negedge clk) reset = 1'b1;
    #(2*QT);

    // burst write
    start(); addr_phase(8'h84, hit); w_ptr(8'h01, hit, ok);
    w_data(8'hAA, ok); w_data(8'hBB, ok); stop_t();
    chk("lit_burst", regs_flat, 32'h00BBAA00);

    // wrap write
    start(); addr_phase(8'h84, hit); w_ptr(8'h03, hit, ok);
    w_data(8'h11, ok); w_data(8'h22, ok); stop_t();
    chk("lit_wrap", regs_flat, 32'h11BBAA22);

    // pointer write, repeated START, 3-byte read
    start(); addr_phase(8'h84, hit); w_ptr(8'h02, hit, ok);
    start(); addr_phase(8'h85, hit);
    r_data(1'b1, d); chk("lit_rd0", d, 8'hBB);
    r_data(1'b1, d); chk("lit_rd1", d, 8'h11);
    r_data(1'b0, d); chk("lit_rd2", d, 8'h22);
    stop_t();

    // read resumes at persisted pointer
    start(); addr_phase(8'h85, hit);
    r_data(1'b0, d); chk("lit_resume", d, 8'hAA);
    stop_t();

    // wrong address
    start(); addr_phase(8'hA0, hit); w_data(8'h55, 1'b0); stop_t();
    chk("lit_wrong_addr", regs_flat, 32'h11BBAA22);

    // out-of-range pointer
    start(); addr_phase(8'h84, hit); w_ptr(8'h07, hit, ok);
    w_data(8'h33, ok); stop_t();

    // STOP after 4 data bits: no write
    start(); addr_phase(8'h84, hit); w_ptr(8'h00, hit, ok);
    for (int i = 0; i < 4; i++) tx_bit(1'b1, s);
    stop_t();
    start(); addr_phase(8'h85, hit);
    r_data(1'b0, d); chk("lit_abort", d, 8'h22);
    stop_t();

    // reset during a read byte
    start(); addr_phase(8'h85, hit);
    pat = m_regs[m_ptr];
    for (int i = 0; i < 3; i++) begin
      rx_bit(s);
      chk("rd_bit", s, pat[7-i]);
    end
    chk("rd_bit_driven", sda_in(), pat[4]);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_sda", sda_in(), 1'b1);
    chk("midrst_regs", regs_flat, '0);
    chk("midrst_busy", busy, 1'b0);
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_ptr  = 0;
    m_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    #QT;
    stop_t();

    // normal operation after reset
    start(); addr_phase(8'h84, hit); w_ptr(8'h03, hit, ok);
    w_data(8'h5A, ok); stop_t();
    start(); addr_phase(8'h84, hit); w_ptr(8'h03, hit, ok);
    start(); addr_phase(8'h85, hit);
    r_data(1'b0, d); chk("lit_post_rst", d, 8'h5A);
    stop_t();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
